// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory: grants one access per cycle,
// blocks illegal accesses, and returns a registered, sign-extended response to the winner.
module dm_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 4,
  parameter int MEM_AW   = 9
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_type,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_type,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        dm_we,
  output logic [2:0]  dm_type,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [2:0] DM_WORD              = 3'd0;
  localparam logic [2:0] DM_HALFWORD          = 3'd1;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'd2;
  localparam logic [2:0] DM_BYTE              = 3'd3;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'd4;

  localparam int              WCW        = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0]  MAX_WAIT_C = WCW'(MAX_WAIT);

  logic           last_q, last_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           rvalid_q, rport_q, rerr_q;
  logic [31:0]    rdata_q, rdata_d;

  logic        tie_to_1, accept, acc_we, acc_err;
  logic [31:0] rdata_ext;

  // Grant depends only on requests and registered arbitration state.
  assign tie_to_1 = (ARB_MODE == 0) ? !last_q : (wait_cnt_q == MAX_WAIT_C);
  assign m1_gnt   = m1_req & (!m0_req | tie_to_1);
  assign m0_gnt   = m0_req & !m1_gnt;
  assign accept   = m0_gnt | m1_gnt;

  assign acc_we   = m1_gnt ? m1_we    : m0_we;
  assign dm_type  = m1_gnt ? m1_type  : m0_type;
  assign dm_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign dm_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign dm_we    = rstn & accept & acc_we & !acc_err;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    acc_err = |dm_addr[31:MEM_AW];
    unique case (dm_type)
      DM_WORD:              if (dm_addr[1:0] != 2'b00) acc_err = 1'b1;
      DM_HALFWORD:          if (dm_addr[0])            acc_err = 1'b1;
      DM_HALFWORD_UNSIGNED: if (dm_addr[0] || acc_we)  acc_err = 1'b1;
      DM_BYTE:              ;
      DM_BYTE_UNSIGNED:     if (acc_we)                acc_err = 1'b1;
      default:              acc_err = 1'b1;
    endcase
  end

  // dm returns sub-words zero-extended; signed types are extended here.
  always_comb begin
    rdata_ext = dm_rdata;
    if (dm_type == DM_HALFWORD) rdata_ext = {{16{dm_rdata[15]}}, dm_rdata[15:0]};
    if (dm_type == DM_BYTE)     rdata_ext = {{24{dm_rdata[7]}},  dm_rdata[7:0]};
  end

  always_comb begin
    last_d     = last_q;
    wait_cnt_d = '0;
    if (accept) last_d = m1_gnt;
    if (m1_req && !m1_gnt)
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + WCW'(1);
    rdata_d = (acc_we || acc_err) ? 32'h0 : rdata_ext;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q     <= 1'b1;
      wait_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rport_q    <= 1'b0;
      rerr_q     <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= accept;
      if (accept) begin
        rport_q <= m1_gnt;
        rerr_q  <= acc_err;
        rdata_q <= rdata_d;
      end
    end
  end

  assign m0_rvalid = rvalid_q & !rport_q;
  assign m1_rvalid = rvalid_q &  rport_q;
  assign m0_err    = m0_rvalid & rerr_q;
  assign m1_err    = m1_rvalid & rerr_q;
  assign m0_rdata  = m0_rvalid ? rdata_q : 32'h0;
  assign m1_rdata  = m1_rvalid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a round-robin and a fixed-priority instance share the
// master stimulus, each in front of its own behavioural dm model.
module tb_dm_arbiter;

  localparam logic [2:0] WORD = 3'd0, HALF = 3'd1, HALFU = 3'd2, BYTE = 3'd3, BYTEU = 3'd4;

  logic        clk, rstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_type, m1_type;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        r_m0_gnt, r_m0_rvalid, r_m0_err, r_m1_gnt, r_m1_rvalid, r_m1_err, r_dm_we;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_dm_addr, r_dm_wdata, r_dm_rdata;
  logic [2:0]  r_dm_type;
  logic        f_m0_gnt, f_m0_rvalid, f_m0_err, f_m1_gnt, f_m1_rvalid, f_m1_err, f_dm_we;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_dm_addr, f_dm_wdata, f_dm_rdata;
  logic [2:0]  f_dm_type;

  int n_checks = 0;
  int n_fails  = 0;

  dm_arbiter #(.ARB_MODE(0), .MAX_WAIT(4), .MEM_AW(9)) u_rr (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_type(m0_type), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(r_m0_gnt), .m0_rvalid(r_m0_rvalid), .m0_rdata(r_m0_rdata), .m0_err(r_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_type(m1_type), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(r_m1_gnt), .m1_rvalid(r_m1_rvalid), .m1_rdata(r_m1_rdata), .m1_err(r_m1_err),
    .dm_we(r_dm_we), .dm_type(r_dm_type), .dm_addr(r_dm_addr), .dm_wdata(r_dm_wdata),
    .dm_rdata(r_dm_rdata)
  );

  dm_arbiter #(.ARB_MODE(1), .MAX_WAIT(4), .MEM_AW(9)) u_fx (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_type(m0_type), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_type(m1_type), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
    .dm_we(f_dm_we), .dm_type(f_dm_type), .dm_addr(f_dm_addr), .dm_wdata(f_dm_wdata),
    .dm_rdata(f_dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dm: writes on the clock edge, reads combinationally, sub-words zero-extended.
  function automatic logic [31:0] dm_wr(input logic [31:0] old, input logic [1:0] off,
                                        input logic [2:0] t, input logic [31:0] d);
    logic [31:0] w;
    w = old;
    case (t)
      WORD:        w = d;
      HALF, HALFU: if (off[1]) w[31:16] = d[15:0]; else w[15:0] = d[15:0];
      BYTE, BYTEU: w[8*off +: 8] = d[7:0];
      default:     ;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] dm_rd(input logic [31:0] w, input logic [1:0] off,
                                        input logic [2:0] t);
    logic [31:0] r;
    r = w;
    case (t)
      HALF, HALFU: r = off[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      BYTE, BYTEU: r = {24'h0, w[8*off +: 8]};
      default:     ;
    endcase
    return r;
  endfunction

  logic [31:0] mem_r [128];
  logic [31:0] mem_f [128];

  always @(posedge clk) begin
    if (r_dm_we) mem_r[r_dm_addr[8:2]] <= dm_wr(mem_r[r_dm_addr[8:2]], r_dm_addr[1:0], r_dm_type, r_dm_wdata);
    if (f_dm_we) mem_f[f_dm_addr[8:2]] <= dm_wr(mem_f[f_dm_addr[8:2]], f_dm_addr[1:0], f_dm_type, f_dm_wdata);
  end

  always_comb begin
    r_dm_rdata = dm_rd(mem_r[r_dm_addr[8:2]], r_dm_addr[1:0], r_dm_type);
    f_dm_rdata = dm_rd(mem_f[f_dm_addr[8:2]], f_dm_addr[1:0], f_dm_type);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_type = t; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_type = t; m1_addr = a; m1_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    set_m0(0, 0, WORD, 32'h0, 32'h0);
    set_m1(0, 0, WORD, 32'h0, 32'h0);
    tick();
    tick();
    mid();
    rstn = 1'b1;
    tick();
  endtask

  localparam logic [2:0]  LD_T [3] = '{BYTE, BYTEU, HALF};
  localparam logic [31:0] LD_A [3] = '{32'h10, 32'h10, 32'h12};
  localparam logic [31:0] LD_E [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000};

  localparam logic        ER_W [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [2:0]  ER_T [6] = '{WORD, WORD, BYTEU, 3'd7, HALF, HALFU};
  localparam logic [31:0] ER_A [6] = '{32'h22, 32'h200, 32'h20, 32'h20, 32'h21, 32'h20};

  initial begin
    // Reset with a store request pending: nothing may reach dm.
    rstn = 1'b0;
    set_m0(1, 1, WORD, 32'h0, 32'hFFFF_FFFF);
    set_m1(0, 0, WORD, 32'h0, 32'h0);
    mid();
    check("rst_m0_rvalid", 32'(r_m0_rvalid), 32'h0);
    check("rst_m1_rvalid", 32'(r_m1_rvalid), 32'h0);
    check("rst_m0_rdata",  r_m0_rdata,       32'h0);
    check("rst_m0_err",    32'(r_m0_err),    32'h0);
    check("rst_dm_we_rr",  32'(r_dm_we),     32'h0);
    check("rst_dm_we_fx",  32'(f_dm_we),     32'h0);
    tick();
    do_reset();

    // Round-robin contention on word 0x20, then a solo load of the final value.
    for (int c = 0; c < 5; c++) begin
      set_m0(1, c < 3, WORD, 32'h20, (c == 0) ? 32'h1111_1111 : 32'h3333_3333);
      set_m1(c < 4, 1, WORD, 32'h20, (c < 2) ? 32'h2222_2222 : 32'h4444_4444);
      mid();
      check($sformatf("rr_gnt0[%0d]", c), 32'(r_m0_gnt), 32'(c % 2 == 0));
      check($sformatf("rr_gnt1[%0d]", c), 32'(r_m1_gnt), 32'(c % 2 == 1));
      tick();
      check($sformatf("rr_rvalid0[%0d]", c), 32'(r_m0_rvalid), 32'(c % 2 == 0));
      check($sformatf("rr_rvalid1[%0d]", c), 32'(r_m1_rvalid), 32'(c % 2 == 1));
    end
    check("rr_final_word", r_m0_rdata, 32'h4444_4444);
    set_m0(0, 0, WORD, 32'h0, 32'h0);
    set_m1(0, 0, WORD, 32'h0, 32'h0);
    tick();
    check("rr_rvalid_drop", 32'(r_m0_rvalid), 32'h0);

    // Preload 0x10, then back-to-back sub-word loads with extension.
    set_m0(1, 1, WORD, 32'h10, 32'h8000_FF80);
    mid();
    check("pre_dm_we", 32'(r_dm_we), 32'h1);
    tick();
    check("pre_rdata_store", r_m0_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      set_m0(1, 0, LD_T[i], LD_A[i], 32'h0);
      mid();
      check($sformatf("ld_dm_we[%0d]", i), 32'(r_dm_we), 32'h0);
      tick();
      check($sformatf("ld_rvalid[%0d]", i), 32'(r_m0_rvalid), 32'h1);
      check($sformatf("ld_rdata[%0d]", i),  r_m0_rdata,       LD_E[i]);
    end

    // Illegal accesses: granted but blocked from dm, error response with zero data.
    for (int i = 0; i < 6; i++) begin
      set_m0(1, ER_W[i], ER_T[i], ER_A[i], 32'hDEAD_BEEF);
      mid();
      check($sformatf("er_gnt[%0d]", i),   32'(r_m0_gnt), 32'h1);
      check($sformatf("er_dm_we[%0d]", i), 32'(r_dm_we),  32'h0);
      tick();
      check($sformatf("er_err[%0d]", i),   32'(r_m0_err), 32'h1);
      check($sformatf("er_rdata[%0d]", i), r_m0_rdata,    32'h0);
    end
    set_m0(1, 0, WORD, 32'h20, 32'h0);
    tick();
    check("er_mem_unchanged", r_m0_rdata,    32'h4444_4444);
    check("er_ok_err",        32'(r_m0_err), 32'h0);

    // Port 1 halfword store, then port 0 word load of the same word next cycle.
    set_m0(0, 0, WORD, 32'h0, 32'h0);
    set_m1(1, 1, HALF, 32'h06, 32'h0000_1234);
    mid();
    check("sl_dm_addr", r_dm_addr, 32'h06);
    check("sl_dm_we",   32'(r_dm_we), 32'h1);
    tick();
    check("sl_m1_rvalid", 32'(r_m1_rvalid), 32'h1);
    set_m1(0, 0, WORD, 32'h0, 32'h0);
    set_m0(1, 0, WORD, 32'h04, 32'h0);
    tick();
    check("sl_m0_rvalid", 32'(r_m0_rvalid),      32'h1);
    check("sl_rdata_hi",  32'(r_m0_rdata[31:16]), 32'h1234);

    // Reset while a response is pending, then the first tie goes to port 0.
    set_m0(1, 0, WORD, 32'h20, 32'h0);
    tick();
    rstn = 1'b0;
    set_m0(0, 0, WORD, 32'h0, 32'h0);
    #1;
    check("rs_rvalid_in_rst", 32'(r_m0_rvalid), 32'h0);
    tick();
    mid();
    rstn = 1'b1;
    tick();
    check("rs_rvalid_after", 32'(r_m0_rvalid | r_m1_rvalid), 32'h0);
    set_m0(1, 0, WORD, 32'h20, 32'h0);
    set_m1(1, 0, WORD, 32'h24, 32'h0);
    mid();
    check("rs_tie_gnt0", 32'(r_m0_gnt), 32'h1);
    check("rs_tie_gnt1", 32'(r_m1_gnt), 32'h0);

    // Fixed priority with starvation guard: port 1 forced through after MAX_WAIT denials.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_m0(1, 0, WORD, 32'h00, 32'h0);
      set_m1(1, 0, WORD, 32'h08, 32'h0);
      mid();
      check($sformatf("fx_gnt0[%0d]", c), 32'(f_m0_gnt), 32'(c != 4));
      check($sformatf("fx_gnt1[%0d]", c), 32'(f_m1_gnt), 32'(c == 4));
      tick();
      check($sformatf("fx_rvalid1[%0d]", c), 32'(f_m1_rvalid), 32'(c == 4));
    end
    set_m0(0, 0, WORD, 32'h0, 32'h0);
    set_m1(0, 0, WORD, 32'h0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
